// File: rtl/clock_pkg.sv
// Shared constants for the settable clock: mode encodings, field limits and widths.
package clock_pkg;

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] SET_HR  = 2'd1;
    localparam logic [1:0] SET_MIN = 2'd2;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    // Mode sequence RUN -> SET_HR -> SET_MIN -> RUN; any other code recovers to RUN.
    function automatic logic [1:0] mode_next(input logic [1:0] cur, input logic adv);
        logic [1:0] nxt;
        nxt = RUN;
        case (cur)
            RUN:     nxt = adv ? SET_HR  : RUN;
            SET_HR:  nxt = adv ? SET_MIN : SET_HR;
            SET_MIN: nxt = adv ? RUN     : SET_MIN;
            default: nxt = RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_wrap_cnt.sv
// Modulo-(MAX+1) counter with synchronous clear; carry flags the MAX->0 step.
module wrap_cnt #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         clr,
    output logic         carry,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic at_max;

    assign at_max = (value == MAX_V);
    assign carry  = enable & at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (enable) begin
            value <= at_max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day counter with button-driven hour/minute setting and a day rollover pulse.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1hz,
    input  logic                btn_mode,
    input  logic                btn_inc,
    output logic [SEC_W-1:0]    sec,
    output logic [MIN_W-1:0]    min,
    output logic [HOUR_W-1:0]   hour,
    output logic [1:0]          mode,
    output logic                day_pulse
);

    logic [1:0] state_q;
    logic [1:0] state_nxt;

    logic in_run;
    logic in_set_hr;
    logic in_set_min;

    logic sec_en;
    logic sec_clr;
    logic min_en;
    logic hour_en;
    logic sec_carry;
    logic min_carry;
    logic hour_carry;

    // Mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next mode: btn_mode advances, illegal code falls back to RUN
    always_comb begin
        state_nxt = state_q;
        state_nxt = mode_next(state_q, btn_mode);
    end

    assign in_run     = (state_q == RUN);
    assign in_set_hr  = (state_q == SET_HR);
    assign in_set_min = (state_q == SET_MIN);

    // Edits act on the field of the current mode, so a coincident btn_mode never redirects them
    assign sec_en  = in_run & tick_1hz;
    assign sec_clr = in_set_min & btn_mode;
    assign min_en  = (in_run & sec_carry) | (in_set_min & btn_inc);
    assign hour_en = (in_run & min_carry) | (in_set_hr & btn_inc);

    wrap_cnt #(
        .MAX (SEC_MAX),
        .W   (SEC_W)
    ) u_sec (
        .clk    (clk),
        .rst    (rst),
        .enable (sec_en),
        .clr    (sec_clr),
        .carry  (sec_carry),
        .value  (sec)
    );

    wrap_cnt #(
        .MAX (MIN_MAX),
        .W   (MIN_W)
    ) u_min (
        .clk    (clk),
        .rst    (rst),
        .enable (min_en),
        .clr    (1'b0),
        .carry  (min_carry),
        .value  (min)
    );

    wrap_cnt #(
        .MAX (HOUR_MAX),
        .W   (HOUR_W)
    ) u_hour (
        .clk    (clk),
        .rst    (rst),
        .enable (hour_en),
        .clr    (1'b0),
        .carry  (hour_carry),
        .value  (hour)
    );

    // Only a timekeeping rollover counts as a new day, never a manual hour edit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_pulse <= 1'b0;
        end else begin
            day_pulse <= in_run & hour_carry;
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench: directed steps queue expected outputs, a monitor compares after each edge.
module tb_clock_set_ctrl;

    logic clk;
    logic rst;

    logic       tick_a, mode_a, inc_a;
    logic [5:0] sec_a, min_a;
    logic [4:0] hour_a;
    logic [1:0] mode_o_a;
    logic       day_a;

    logic       tick_b, mode_b, inc_b;
    logic [5:0] sec_b, min_b;
    logic [4:0] hour_b;
    logic [1:0] mode_o_b;
    logic       day_b;

    typedef struct {
        bit         sel;
        bit         chk;
        int         id;
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic [1:0] mo;
        logic       d;
    } exp_t;

    exp_t q[$];

    int vectors;
    int miscompares;

    clock_set_ctrl u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_a),
        .btn_mode  (mode_a),
        .btn_inc   (inc_a),
        .sec       (sec_a),
        .min       (min_a),
        .hour      (hour_a),
        .mode      (mode_o_a),
        .day_pulse (day_a)
    );

    clock_set_ctrl #(
        .HOUR_MAX (11)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_b),
        .btn_mode  (mode_b),
        .btn_inc   (inc_b),
        .sec       (sec_b),
        .min       (min_b),
        .hour      (hour_b),
        .mode      (mode_o_b),
        .day_pulse (day_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are registered, so compare 1 time unit after the edge that produced them
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] s, m;
            logic [4:0] h;
            logic [1:0] mo;
            logic       d;
            e = q.pop_front();
            s  = e.sel ? sec_b    : sec_a;
            m  = e.sel ? min_b    : min_a;
            h  = e.sel ? hour_b   : hour_a;
            mo = e.sel ? mode_o_b : mode_o_a;
            d  = e.sel ? day_b    : day_a;
            if (e.chk) begin
                vectors++;
                if (s !== e.s || m !== e.m || h !== e.h || mo !== e.mo || d !== e.d) begin
                    miscompares++;
                    $display("FAIL vec%0d dut%0d: got %0d:%0d:%0d mode=%0d day=%0b, want %0d:%0d:%0d mode=%0d day=%0b",
                             e.id, e.sel, h, m, s, mo, d, e.h, e.m, e.s, e.mo, e.d);
                end
            end
        end
    end

    task automatic step(input bit sel, input logic t, input logic md, input logic i,
                        input bit chk, input int id,
                        input int eh, input int em, input int es, input int emo, input logic ed);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            tick_b = t; mode_b = md; inc_b = i;
        end else begin
            tick_a = t; mode_a = md; inc_a = i;
        end
        e.sel = sel; e.chk = chk; e.id = id;
        e.s = 6'(es); e.m = 6'(em); e.h = 5'(eh); e.mo = 2'(emo); e.d = ed;
        q.push_back(e);
    endtask

    // Repeat one input pattern n times, checking only the final state
    task automatic repeat_step(input bit sel, input logic t, input logic md, input logic i,
                               input int n, input int id,
                               input int eh, input int em, input int es, input int emo);
        for (int k = 0; k < n; k++)
            step(sel, t, md, i, (k == n - 1), id, eh, em, es, emo, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: queue depth %0d, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_now(input int id, input logic [5:0] s, input logic [5:0] m,
                             input logic [4:0] h, input logic [1:0] mo, input logic d);
        vectors++;
        if (sec_a !== s || min_a !== m || hour_a !== h || mode_o_a !== mo || day_a !== d) begin
            miscompares++;
            $display("FAIL vec%0d async: got %0d:%0d:%0d mode=%0d day=%0b, want %0d:%0d:%0d mode=%0d day=%0b",
                     id, hour_a, min_a, sec_a, mode_o_a, day_a, h, m, s, mo, d);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        tick_a = 0; mode_a = 0; inc_a = 0;
        tick_b = 0; mode_b = 0; inc_b = 0;
        rst = 1'b1;
        #12;
        check_now(0, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // RUN basics: ticks count, btn_inc ignored
        repeat_step(0, 1, 0, 0, 5, 1, 0, 0, 5, 0);
        step(0, 0, 0, 1, 1, 2, 0, 0, 5, 0, 1'b0);
        // Hour edit, ticks frozen while setting
        step(0, 0, 1, 0, 1, 3, 0, 0, 5, 1, 1'b0);
        step(0, 1, 0, 0, 1, 4, 0, 0, 5, 1, 1'b0);
        repeat_step(0, 0, 0, 1, 22, 5, 22, 0, 5, 1);
        step(0, 0, 0, 1, 1, 6, 23, 0, 5, 1, 1'b0);
        step(0, 0, 0, 1, 1, 7, 0, 0, 5, 1, 1'b0);
        step(0, 0, 0, 1, 1, 8, 1, 0, 5, 1, 1'b0);
        step(0, 0, 0, 0, 1, 9, 1, 0, 5, 1, 1'b0);
        repeat_step(0, 0, 0, 1, 22, 10, 23, 0, 5, 1);
        // Minute edit: wrap without hour carry, exit clears seconds
        step(0, 0, 1, 0, 1, 11, 23, 0, 5, 2, 1'b0);
        repeat_step(0, 0, 0, 1, 59, 12, 23, 59, 5, 2);
        step(0, 0, 0, 1, 1, 13, 23, 0, 5, 2, 1'b0);
        repeat_step(0, 0, 0, 1, 59, 14, 23, 59, 5, 2);
        step(0, 1, 0, 0, 1, 15, 23, 59, 5, 2, 1'b0);
        step(0, 0, 1, 0, 1, 16, 23, 59, 0, 0, 1'b0);
        // Full carry chain into a new day
        repeat_step(0, 1, 0, 0, 58, 17, 23, 59, 58, 0);
        step(0, 1, 0, 0, 1, 18, 23, 59, 59, 0, 1'b0);
        step(0, 1, 0, 0, 1, 19, 0, 0, 0, 0, 1'b1);
        step(0, 0, 0, 0, 1, 20, 0, 0, 0, 0, 1'b0);
        // Tick and mode together in RUN
        repeat_step(0, 1, 0, 0, 59, 21, 0, 0, 59, 0);
        step(0, 1, 1, 0, 1, 22, 0, 1, 0, 1, 1'b0);
        step(0, 1, 0, 0, 1, 23, 0, 1, 0, 1, 1'b0);
        // Increment and mode together in each SET state
        step(0, 0, 1, 1, 1, 24, 1, 1, 0, 2, 1'b0);
        step(0, 0, 1, 1, 1, 25, 1, 2, 0, 0, 1'b0);
        // Park in SET_MIN at 12:34:00 for the reset case
        step(0, 0, 1, 0, 1, 26, 1, 2, 0, 1, 1'b0);
        repeat_step(0, 0, 0, 1, 11, 27, 12, 2, 0, 1);
        step(0, 0, 1, 0, 1, 28, 12, 2, 0, 2, 1'b0);
        repeat_step(0, 0, 0, 1, 32, 29, 12, 34, 0, 2);
        step(0, 0, 0, 0, 1, 30, 12, 34, 0, 2, 1'b0);
        drain();

        // Asynchronous reset mid-edit
        #1;
        rst = 1'b1;
        #1;
        check_now(31, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        check_now(32, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 0, 0, 1, 33, 0, 0, 1, 0, 1'b0);
        step(0, 0, 1, 0, 1, 34, 0, 0, 1, 1, 1'b0);
        step(0, 0, 0, 0, 1, 35, 0, 0, 1, 1, 1'b0);

        // 12 h instance: preset 11:59:59 and roll over
        step(1, 0, 1, 0, 1, 40, 0, 0, 0, 1, 1'b0);
        repeat_step(1, 0, 0, 1, 11, 41, 11, 0, 0, 1);
        step(1, 0, 0, 1, 1, 42, 0, 0, 0, 1, 1'b0);
        repeat_step(1, 0, 0, 1, 11, 43, 11, 0, 0, 1);
        step(1, 0, 1, 0, 1, 44, 11, 0, 0, 2, 1'b0);
        repeat_step(1, 0, 0, 1, 59, 45, 11, 59, 0, 2);
        step(1, 0, 1, 0, 1, 46, 11, 59, 0, 0, 1'b0);
        repeat_step(1, 1, 0, 0, 59, 47, 11, 59, 59, 0);
        step(1, 1, 0, 0, 1, 48, 0, 0, 0, 0, 1'b1);
        step(1, 0, 0, 0, 1, 49, 0, 0, 0, 0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
